// File: rtl/fp32_to_fixed_conv.sv
// -----------------------------------------------------------------------------
// fp32_to_fixed_conv
//
// Converts IEEE-754 single-precision words from the FFT float datapath into
// signed two's-complement fixed-point samples for the FFT sink side.
// result = round_toward_zero(x * 2^FRAC), saturated to WIDTH bits.
//
// Two-stage pipeline:
//   stage 1 (unpack)   : sign, 24-bit mantissa with hidden one, shift amount,
//                        input class (zero / normal / inf / nan)
//   stage 2 (shift+sat): barrel shift, saturation, sign application, flags
//
// Both stages advance together on adv = ~out_valid | out_ready, so a full pipe
// still sustains one word per cycle and a stalled sink freezes every register.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      in_data is valid
//   in_ready   out  1      block accepts in_data this cycle
//   in_data    in   32     fp32 operand: [31] sign, [30:23] exponent, [22:0] mantissa
//   out_valid  out  1      out_data and the flags are valid
//   out_ready  in   1      the sink accepts out_data this cycle
//   out_data   out  WIDTH  signed fixed-point result
//   out_ovf    out  1      result was saturated (|x| out of range, or Inf)
//   out_nan    out  1      input was NaN
// -----------------------------------------------------------------------------
module fp32_to_fixed_conv #(
  parameter int WIDTH = 16,  // output word width, 2..32
  parameter int FRAC  = 8    // fractional bits of the output, 0..WIDTH-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_nan
);

  typedef enum logic [1:0] {
    CLS_ZERO,   // exponent 0: true zero or denormal (flushed)
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_e;

  // Magnitude working width: a non-saturating left shift is at most WIDTH-24
  // places, so mant24 << sh never exceeds WIDTH+1 bits; WIDTH+24 also holds
  // the unshifted mantissa when WIDTH is small.
  localparam int MW = WIDTH + 24;

  // sh = e - 127 + FRAC - 23 = e + (FRAC - 150)
  localparam logic signed [9:0] SH_OFS = 10'(FRAC - 150);

  // Any sh at or above this puts the hidden one at bit >= WIDTH, i.e. the
  // magnitude is >= 2^WIDTH and saturates for either sign.
  localparam logic signed [9:0] BIG_SH = 10'(WIDTH - 23);

  localparam logic [MW-1:0]    POS_MAX  = {{(MW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [MW-1:0]    NEG_MAG  = {{(MW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] POS_DATA = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_DATA = {1'b1, {(WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack
  // ---------------------------------------------------------------------------
  logic [7:0]         in_exp;
  logic [22:0]        in_man;
  logic signed [9:0]  in_sh;
  cls_e               in_cls;

  assign in_exp = in_data[30:23];
  assign in_man = in_data[22:0];
  assign in_sh  = $signed({2'b00, in_exp}) + SH_OFS;

  always_comb begin
    if (in_exp == 8'h00) begin
      in_cls = CLS_ZERO;
    end else if (in_exp == 8'hFF) begin
      in_cls = (in_man == '0) ? CLS_INF : CLS_NAN;
    end else begin
      in_cls = CLS_NORM;
    end
  end

  logic               s1_v;
  logic               s1_sign;
  logic [23:0]        s1_mant;
  logic signed [9:0]  s1_sh;
  cls_e               s1_cls;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of always_ff evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
    end else if (adv) begin
      s1_v <= in_valid;
    end
  end

  // NOTE: the stage-1 payload has no reset; it is only ever consumed when
  // s1_v says it is valid, and leaving it out keeps the reset net small.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= in_data[31];
      s1_mant <= {1'b1, in_man};
      s1_sh   <= in_sh;
      s1_cls  <= in_cls;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift and saturate
  // ---------------------------------------------------------------------------
  logic [MW-1:0]    mant_w;
  logic [MW-1:0]    mag;
  logic [9:0]       rsh;
  logic             big;
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_ovf;
  logic             nxt_nan;

  assign mant_w = {{(MW-24){1'b0}}, s1_mant};
  assign rsh    = -s1_sh;
  assign big    = (s1_sh >= BIG_SH);

  // Right shifts by 24 or more fall off the vector and give 0 (underflow).
  // The left-shift result is only meaningful when big is clear.
  always_comb begin
    if (s1_sh[9]) begin
      mag = mant_w >> rsh;
    end else begin
      mag = mant_w << s1_sh[9:0];
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    nxt_data = '0;
    nxt_ovf  = 1'b0;
    nxt_nan  = 1'b0;
    case (s1_cls)
      CLS_NAN: begin
        nxt_nan = 1'b1;
      end
      CLS_INF: begin
        nxt_ovf  = 1'b1;
        nxt_data = s1_sign ? NEG_DATA : POS_DATA;
      end
      CLS_NORM: begin
        if (!s1_sign) begin
          if (big || (mag > POS_MAX)) begin
            nxt_data = POS_DATA;
            nxt_ovf  = 1'b1;
          end else begin
            nxt_data = mag[WIDTH-1:0];
          end
        end else begin
          // The negative range reaches one further: -2^(WIDTH-1) is exact.
          if (big || (mag > NEG_MAG)) begin
            nxt_data = NEG_DATA;
            nxt_ovf  = 1'b1;
          end else if (mag == NEG_MAG) begin
            nxt_data = NEG_DATA;
          end else begin
            nxt_data = -mag[WIDTH-1:0];  // -0 stays 0
          end
        end
      end
      default: begin
        // CLS_ZERO: zero and flushed denormals give 0, no flags
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_nan   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_v;
      out_data  <= nxt_data;
      out_ovf   <= nxt_ovf;
      out_nan   <= nxt_nan;
    end
  end

endmodule

// File: tb/tb_fp32_to_fixed_conv.sv
// -----------------------------------------------------------------------------
// tb_fp32_to_fixed_conv
//
// Self-checking bench for fp32_to_fixed_conv (WIDTH=16, FRAC=8). A behavioural
// model computes each expected result from the input value with plain integer
// arithmetic and a signed clamp; accepted words are queued and one negedge
// process compares every valid output against the queue head, also checking
// that a stalled output holds still. Directed sequences cover the literal
// cases, backpressure and mid-stream reset; a random phase covers the rest.
// -----------------------------------------------------------------------------
module tb_fp32_to_fixed_conv;

  localparam int     W    = 16;
  localparam int     F    = 8;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (W-1));
  localparam int     NRND = 10000;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data   = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         out_nan;

  fp32_to_fixed_conv #(.WIDTH(W), .FRAC(F)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_nan   (out_nan)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         ovf;
    logic         nan;
    int           acc;
  } exp_t;

  // Value-level model: x * 2^F truncated toward zero, then clamped.
  function automatic exp_t model(input logic [31:0] x);
    exp_t   r;
    int     e    = int'(x[30:23]);
    longint mant = longint'({1'b1, x[22:0]});
    int     sh;
    longint mag;
    longint val;
    r.d   = '0;
    r.ovf = 1'b0;
    r.nan = 1'b0;
    r.acc = 0;
    if (e == 0) begin
      r.d = '0;
    end else if (e == 255) begin
      if (x[22:0] != 23'd0) begin
        r.nan = 1'b1;
      end else begin
        r.ovf = 1'b1;
        r.d   = x[31] ? MINV[W-1:0] : MAXV[W-1:0];
      end
    end else begin
      sh = e - 150 + F;
      if (sh <= -24)     mag = 0;
      else if (sh < 0)   mag = mant >> (-sh);
      else if (sh > 30)  mag = 64'sd1 <<< 54;
      else               mag = mant <<< sh;
      val = x[31] ? -mag : mag;
      if (val > MAXV) begin
        r.d   = MAXV[W-1:0];
        r.ovf = 1'b1;
      end else if (val < MINV) begin
        r.d   = MINV[W-1:0];
        r.ovf = 1'b1;
      end else begin
        r.d = val[W-1:0];
      end
    end
    return r;
  endfunction

  task automatic pin(input logic [31:0] x, input logic [W-1:0] d, input logic ovf, input logic nan);
    exp_t r = model(x);
    check($sformatf("model_%h_data", x), 32'(r.d), 32'(d));
    check($sformatf("model_%h_ovf", x), 32'(r.ovf), 32'(ovf));
    check($sformatf("model_%h_nan", x), 32'(r.nan), 32'(nan));
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard / compare process
  // ---------------------------------------------------------------------------
  exp_t         sb[$];
  int           lat_q[$];
  int           n_pop  = 0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d;
  logic         hold_o;
  logic         hold_n;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 32'(out_valid), 32'(1'b1));
        check("hold_data", 32'(out_data), 32'(hold_d));
        check("hold_ovf", 32'(out_ovf), 32'(hold_o));
        check("hold_nan", 32'(out_nan), 32'(hold_n));
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'(1'b0));
        end else begin
          e = sb[0];
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_ovf", 32'(out_ovf), 32'(e.ovf));
          check("out_nan", 32'(out_nan), 32'(e.nan));
          if (out_ready) begin
            void'(sb.pop_front());
            lat_q.push_back(cyc - e.acc);
            n_pop++;
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      hold_o = out_ovf;
      hold_n = out_nan;
      if (in_valid && in_ready) begin
        e     = model(in_data);
        e.acc = cyc;
        sb.push_back(e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  // Presents w and returns just after the edge that accepts it, leaving
  // in_valid high so consecutive calls stream back to back.
  task automatic send(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout_in_ready", 32'(in_ready), 32'(1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom();
    case ($urandom_range(0, 9))
      0: w[30:23] = 8'h00;
      1: w[30:23] = 8'hFF;
      2: begin
        w[30:23] = 8'hFF;
        w[22:0]  = '0;
      end
      3: begin
        w[30:23] = 8'd134;
        w[22:0]  = 23'($urandom_range(0, 3));
      end
      4: begin
        w[30:23] = 8'd133;
        w[22:0]  = 23'h7FFF00 | 23'($urandom_range(0, 255));
      end
      default: w[30:23] = 8'($urandom_range(110, 145));
    endcase
    return w;
  endfunction

  logic [31:0] dir_w [13] = '{
    32'h43480000, 32'hC3480000, 32'hC3000000, 32'h42FFFF00,
    32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h3A83126F,
    32'h00000001, 32'h80000001, 32'h3F800000, 32'hBB800000,
    32'h3B800000
  };

  logic [31:0] bp_w [8] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000
  };

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   pop0;
    logic saw_block;
    int   sent;
    int   guard;
    logic acc;

    // Hand-computed literals that pin the model itself.
    pin(32'h3FC00000, 16'h0180, 1'b0, 1'b0);
    pin(32'hBFC00000, 16'hFE80, 1'b0, 1'b0);
    pin(32'h80000000, 16'h0000, 1'b0, 1'b0);
    pin(32'h43480000, 16'h7FFF, 1'b1, 1'b0);
    pin(32'hC3480000, 16'h8000, 1'b1, 1'b0);
    pin(32'hC3000000, 16'h8000, 1'b0, 1'b0);
    pin(32'h42FFFF00, 16'h7FFF, 1'b0, 1'b0);
    pin(32'h7F800000, 16'h7FFF, 1'b1, 1'b0);
    pin(32'hFF800000, 16'h8000, 1'b1, 1'b0);
    pin(32'h7FC00000, 16'h0000, 1'b0, 1'b1);
    pin(32'h3A83126F, 16'h0000, 1'b0, 1'b0);
    pin(32'h00000001, 16'h0000, 1'b0, 1'b0);
    pin(32'hBB800000, 16'hFFFF, 1'b0, 1'b0);  // -2^-8 -> -1 LSB

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_out_nan", 32'(out_nan), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1. Basic stream, latency 2, back to back
    out_ready = 1'b1;
    lat_q.delete();
    send(32'h3FC00000);
    send(32'hBFC00000);
    send(32'h00000000);
    send(32'h80000000);
    drain();
    check("t1_count", 32'(lat_q.size()), 32'd4);
    foreach (lat_q[i]) check($sformatf("t1_latency_%0d", i), 32'(lat_q[i]), 32'd2);

    // 2/3. Saturation, limits, special values
    foreach (dir_w[i]) send(dir_w[i]);
    drain();

    // 4. Backpressure mid-stream
    pop0      = n_pop;
    saw_block = 1'b0;
    fork
      begin
        foreach (bp_w[i]) send(bp_w[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (out_valid && !in_ready) saw_block = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("t4_in_ready_dropped", 32'(saw_block), 32'd1);
    check("t4_pop_count", 32'(n_pop - pop0), 32'd8);

    // 5. Reset with two words in flight
    send(32'h40000000);
    send(32'hC0400000);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t5_out_valid_after_rst", 32'(out_valid), 32'd0);
    check("t5_out_data_after_rst", 32'(out_data), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("t5_no_stale_word", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    lat_q.delete();
    send(32'h40A00000);
    drain();
    check("t5_count", 32'(lat_q.size()), 32'd1);
    if (lat_q.size() > 0) check("t5_latency", 32'(lat_q[0]), 32'd2);

    // 6. Random traffic
    sent  = 0;
    guard = 0;
    while (sent < NRND && guard < 60000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) sent++;
      if (!in_valid || acc) begin
        if (sent < NRND && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_data  = rand_word();
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    check("t6_words_sent", 32'(sent), 32'(NRND));
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
